// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {OCIOSO, CONVERTE} estado_t;

  localparam logic [3:0] BCD_LIMIAR = 4'd5;
  localparam logic [3:0] BCD_AJUSTE = 4'd3;

  // Decimal digits needed to represent 2**largura - 1.
  function automatic int digitos_necessarios(input int largura);
    longint unsigned v;
    int n;
    v = (longint'(1) << largura) - 1;
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

endpackage

// File: rtl/conversor_bcd_ajuste_digito.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module ajuste_digito
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_LIMIAR) ? d + BCD_AJUSTE : d;

endmodule

// File: rtl/conversor_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input: define BCD_SINAL_EN.
module conversor_bcd_seq
  import bcd_pkg::*;
#(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     binario,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   negativo
);

  localparam int CW = $clog2(LARGURA + 1);
`ifdef BCD_SINAL_EN
  // Magnitude 2**(LARGURA-1) has the same digit count as 2**(LARGURA-1) - 1.
  localparam int NECESSARIOS = digitos_necessarios(LARGURA - 1);
`else
  localparam int NECESSARIOS = digitos_necessarios(LARGURA);
`endif

  if (LARGURA < 4 || LARGURA > 32) begin : g_erro_largura
    $error("conversor_bcd_seq: LARGURA fora de 4..32");
  end
  if (DIGITOS < NECESSARIOS) begin : g_erro_digitos
    $error("conversor_bcd_seq: DIGITOS insuficiente para LARGURA");
  end

  estado_t                estado, estado_prox;
  logic                   carrega, passo, fim;
  logic [CW-1:0]          cnt;
  logic [LARGURA-1:0]     sr, sr_next, mag;
  logic [4*DIGITOS-1:0]   acc, adj, acc_next;
  logic                   sinal_in;
  logic                   unused_msb;

`ifdef BCD_SINAL_EN
  logic signed [LARGURA-1:0] bin_s;
  logic                      sinal;

  assign bin_s    = binario;
  assign sinal_in = bin_s[LARGURA-1];
  // Negating the most negative value wraps to itself, which read unsigned is the right magnitude.
  assign mag      = sinal_in ? $unsigned(-bin_s) : binario;
`else
  assign sinal_in = 1'b0;
  assign mag      = binario;
`endif

  for (genvar k = 0; k < DIGITOS; k++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .d (acc[4*k +: 4]),
      .q (adj[4*k +: 4])
    );
  end

  // Accumulator and shift register move left as one register.
  assign acc_next   = {adj[4*DIGITOS-2:0], sr[LARGURA-1]};
  assign sr_next    = {sr[LARGURA-2:0], 1'b0};
  assign unused_msb = adj[4*DIGITOS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    carrega     = 1'b0;
    passo       = 1'b0;
    fim         = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          carrega     = 1'b1;
          estado_prox = CONVERTE;
        end
      end
      CONVERTE: begin
        passo = 1'b1;
        if (cnt == CW'(1)) begin
          fim         = 1'b1;
          estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sr     <= '0;
      acc    <= '0;
      bcd    <= '0;
      pronto <= 1'b0;
    end else begin
      pronto <= fim;
      if (carrega) begin
        sr  <= mag;
        acc <= '0;
        cnt <= CW'(LARGURA);
      end else if (passo) begin
        sr  <= sr_next;
        acc <= acc_next;
        cnt <= cnt - CW'(1);
      end
      if (fim) bcd <= acc_next;
    end
  end

`ifdef BCD_SINAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinal    <= 1'b0;
      negativo <= 1'b0;
    end else begin
      if (carrega) sinal <= sinal_in;
      if (fim)     negativo <= sinal;
    end
  end
`else
  assign negativo = 1'b0;
  logic unused_sinal;
  assign unused_sinal = sinal_in;
`endif

  assign ocupado = (estado == CONVERTE);

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Directed bench for conversor_bcd_seq: default 16/5 instance plus an 8/3 instance.
module tb_conversor_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic [15:0] binario = '0;
  logic        ocupado, pronto, negativo;
  logic [19:0] bcd;

  logic        inicio8 = 1'b0;
  logic [7:0]  binario8 = '0;
  logic        ocupado8, pronto8, negativo8;
  logic [11:0] bcd8;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;
  int n, t0, npr;

`ifdef BCD_SINAL_EN
  localparam logic [19:0] EXP_FULL  = 20'h00001;
  localparam logic        NEG_FULL  = 1'b1;
  localparam logic [11:0] EXP_FULL8 = 12'h001;
  localparam logic        NEG_FULL8 = 1'b1;
`else
  localparam logic [19:0] EXP_FULL  = 20'h65535;
  localparam logic        NEG_FULL  = 1'b0;
  localparam logic [11:0] EXP_FULL8 = 12'h255;
  localparam logic        NEG_FULL8 = 1'b0;
`endif

  conversor_bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .binario(binario),
    .ocupado(ocupado), .pronto(pronto), .bcd(bcd), .negativo(negativo)
  );

  conversor_bcd_seq #(.LARGURA(8), .DIGITOS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio8), .binario(binario8),
    .ocupado(ocupado8), .pronto(pronto8), .bcd(bcd8), .negativo(negativo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges counted from the current point until pronto is seen, bounded.
  task automatic wait_pronto(output int cnt);
    cnt = 0;
    while (pronto !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("pronto_timeout", {31'd0, pronto}, 32'd1);
  endtask

  task automatic aceita(input logic [15:0] v);
    binario = v;
    inicio  = 1'b1;
    @(posedge clk); #1;
    inicio  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_pronto",  {31'd0, pronto},  32'd0);
    chk("rst_bcd",     {12'd0, bcd},     32'd0);
    chk("rst_neg",     {31'd0, negativo}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full scale, latency
    aceita(16'hFFFF);
    chk("full_ocupado_e0", {31'd0, ocupado}, 32'd1);
    wait_pronto(n);
    chk("full_lat", n, 32'd16);
    chk("full_bcd", {12'd0, bcd}, {12'd0, EXP_FULL});
    chk("full_neg", {31'd0, negativo}, {31'd0, NEG_FULL});
    chk("full_ocupado_pr", {31'd0, ocupado}, 32'd0);
    @(posedge clk); #1;
    chk("full_pulse", {31'd0, pronto}, 32'd0);

    // Back-to-back 0, 9, 9999
    aceita(16'd0);
    wait_pronto(n);
    chk("b2b_0", {12'd0, bcd}, 32'h00000);
    t0 = cyc;
    aceita(16'd9);
    wait_pronto(n);
    chk("b2b_9", {12'd0, bcd}, 32'h00009);
    chk("b2b_gap1", cyc - t0, 32'd17);
    t0 = cyc;
    aceita(16'd9999);
    wait_pronto(n);
    chk("b2b_9999", {12'd0, bcd}, 32'h09999);
    chk("b2b_gap2", cyc - t0, 32'd17);

    // Busy rejection with inicio held high
    binario = 16'd4321;
    inicio  = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    binario = 16'd1234;
    wait_pronto(n);
    chk("busy_first", {12'd0, bcd}, 32'h04321);
    chk("busy_lat", n, 32'd11);
    @(posedge clk); #1;
    inicio = 1'b0;
    chk("busy_reaccept", {31'd0, ocupado}, 32'd1);
    wait_pronto(n);
    chk("busy_second", {12'd0, bcd}, 32'h01234);
    chk("busy_lat2", n, 32'd16);

    // Asynchronous reset mid-conversion
    aceita(16'd500);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("arst_pronto",  {31'd0, pronto},  32'd0);
    chk("arst_bcd",     {12'd0, bcd},     32'd0);
    chk("arst_neg",     {31'd0, negativo}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    npr = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pronto) npr++;
    end
    chk("arst_no_pronto", npr, 32'd0);
    aceita(16'd500);
    wait_pronto(n);
    chk("arst_fresh", {12'd0, bcd}, 32'h00500);

    // Sign handling
    aceita(16'h8000);
    wait_pronto(n);
    chk("s8000_bcd", {12'd0, bcd}, 32'h32768);
`ifdef BCD_SINAL_EN
    chk("s8000_neg", {31'd0, negativo}, 32'd1);
    aceita(16'hFFFF);
    wait_pronto(n);
    chk("sFFFF_bcd", {12'd0, bcd}, 32'h00001);
    chk("sFFFF_neg", {31'd0, negativo}, 32'd1);
`else
    chk("u8000_neg", {31'd0, negativo}, 32'd0);
`endif
    aceita(16'd100);
    wait_pronto(n);
    chk("s100_bcd", {12'd0, bcd}, 32'h00100);
    chk("s100_neg", {31'd0, negativo}, 32'd0);

    // 8-bit / 3-digit instance
    binario8 = 8'hFF;
    inicio8  = 1'b1;
    @(posedge clk); #1;
    inicio8  = 1'b0;
    n = 0;
    while (pronto8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("p8_lat", n, 32'd8);
    chk("p8_bcd", {20'd0, bcd8}, {20'd0, EXP_FULL8});
    chk("p8_neg", {31'd0, negativo8}, {31'd0, NEG_FULL8});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/conversor_bcd_seq.md
# conversor_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It succeeds the combinational 16-bit/5-digit converter. It adds a configurable input width and digit count, a start/done handshake, a registered output and optional two's-complement input. It sits between the datapath counters and the 7-segment display drivers, where a fixed multi-cycle latency is acceptable in exchange for area.

## Interface
- `LARGURA`, default 16: input binary width; legal range 4..32.
- `DIGITOS`, default 5: BCD output digits.
  - Must satisfy `DIGITOS >= ceil(LARGURA*log10(2))`.
  - Elaboration fails otherwise.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `inicio`, input, 1: start request; sampled only while idle.
- `binario`, input, `LARGURA`: value to convert; captured on the edge that accepts `inicio`.
- `ocupado`, output, 1: conversion in progress.
- `pronto`, output, 1: one-cycle pulse; `bcd` (and `negativo`) updated.
- `bcd`, output, `4*DIGITOS`: result; digit k at bits [4k+3:4k], k=0 is units.
- `negativo`, output, 1: sign of the last result; constant 0 unless `BCD_SINAL_EN` is defined.

## Operation
- **States**: `OCIOSO`, `CONVERTE`.
- **OCIOSO**
  - `inicio`=1 at a rising edge loads the shift register with `binario` (or its magnitude, see Configuration).
  - The same edge clears the BCD accumulator, sets the bit counter to `LARGURA` and moves to `CONVERTE`.
  - `inicio`=0: state is held.
- **CONVERTE**, each edge:
  - Every accumulator digit >= 5 gets +3 (4-bit, no carry out).
  - The accumulator and shift register then shift left as one register; the MSB of `binario` enters digit 0 bit 0.
  - The counter decrements.
  - On the edge where the counter goes 1→0, the adjusted and shifted accumulator is written to `bcd`, `pronto` is set for one cycle and the state returns to `OCIOSO`.
- `inicio` during `CONVERTE` is ignored; no queuing.
- `bcd`/`negativo` hold the previous result until the next completion.
- Unused upper digits (when `DIGITOS` exceeds the need) always read 0.
- **Reset** (any time, including mid-conversion) returns immediately to:
  - state `OCIOSO`
  - `ocupado`=0, `pronto`=0
  - `bcd`=0, `negativo`=0
  - counter, accumulator and shift register all 0

## Timing
- Edge E0 accepts `inicio`: `ocupado`=1 from after E0 until after edge E0+`LARGURA`.
- `pronto`=1 and the new `bcd` are visible in the cycle after edge E0+`LARGURA`. Latency is `LARGURA` cycles from acceptance to `pronto`.
- `ocupado` and `pronto` are never 1 in the same cycle.
- Back-to-back: `inicio` high during the `pronto` cycle is accepted. Sustained throughput is one conversion per `LARGURA`+1 cycles.
- `binario` may change freely after E0.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- **Macro `BCD_SINAL_EN`**
  - **Defined**:
    - `binario` is two's complement.
    - At load, the shift register receives |`binario|` (`LARGURA` bits unsigned). −2^(`LARGURA`−1) yields 2^(`LARGURA`−1) correctly.
    - The sign is stored and presented on `negativo` together with `bcd` at `pronto`.
    - `DIGITOS` legality uses `LARGURA`−1 magnitude bits plus the most-negative case.
  - **Not defined**:
    - `binario` is unsigned.
    - `negativo` is tied to 0 and no sign logic exists.
  - Latency is identical in both builds.

## Structure
- Package `bcd_pkg`:
  - state enum (`OCIOSO`, `CONVERTE`)
  - constant function `digitos_necessarios(largura)` used in the elaboration check
  - constant `BCD_LIMIAR` = 5, `BCD_AJUSTE` = 3
- Sub-module `ajuste_digito`: combinational 4-bit "≥5 then +3" cell, instantiated `DIGITOS` times in a generate loop.
- The top holds the FSM, counter, shift register and output registers.

## Test plan
- **Default parameters, full-scale**: `binario`=65535, `inicio` one cycle.
  - `ocupado` for 16 cycles.
  - `pronto` pulse in cycle 17 after acceptance.
  - `bcd`=20'h65535.
- **Zero and small values**: `binario`=0 then 9 then 9999 back-to-back, `inicio` reasserted in each `pronto` cycle.
  - `bcd`=20'h00000, 20'h00009, 20'h09999.
  - Each result exactly 17 cycles apart.
- **Busy rejection**: `inicio` held high throughout, with `binario` changed to 1234 mid-conversion of 4321.
  - First result 20'h04321.
  - Next accepted conversion starts in the `pronto` cycle.
- **Reset mid-operation**: `rst_n` low at cycle 8 of a conversion of 500.
  - All outputs 0 asynchronously.
  - No `pronto`.
  - A fresh conversion of 500 afterwards yields 20'h00500.
- **Parametrised**: `LARGURA`=8, `DIGITOS`=3, `binario`=255 → `bcd`=12'h255 after 8 cycles.
  - `LARGURA`=8, `DIGITOS`=2 fails elaboration.
- **`BCD_SINAL_EN` defined**:
  - `binario`=16'h8000 → `bcd`=20'h32768, `negativo`=1.
  - `binario`=16'hFFFF → 20'h00001, `negativo`=1.
  - `binario`=100 → 20'h00100, `negativo`=0.
